// File: rtl/ptch_fusion_integ.sv
// Pitch integrator with accel-based drift correction for the balance controller.
// Define PTCH_SAT_EN to clamp the pitch accumulator instead of letting it wrap.
module ptch_fusion_integ #(
    parameter logic [15:0] PTCH_RT_OFFSET = 16'h0050,
    parameter logic [15:0] AZ_OFFSET      = 16'h00A0,
    parameter int          ACC_SCALE      = 327,
    parameter int          FAST_CNT       = 256,
    parameter int          FAST_GAIN      = 8192,
    parameter int          SLOW_GAIN      = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vld,
    input  logic [15:0] ptch_rt,
    input  logic [15:0] AZ,
    output logic [15:0] ptch,
    output logic        ptch_vld,
    output logic        settled
);

    localparam int unsigned DW   = 16;
    localparam int unsigned PW   = 26;
    localparam int unsigned IW   = 27;
    localparam int unsigned CW   = 9;

    localparam logic signed [PW-1:0] SCALE  = PW'(ACC_SCALE);
    localparam logic signed [IW-1:0] FAST_G = IW'(FAST_GAIN);
    localparam logic signed [IW-1:0] SLOW_G = IW'(SLOW_GAIN);
    localparam logic [CW-1:0]        LAST   = CW'(FAST_CNT - 1);

    logic signed [IW-1:0] ptch_int;
    logic [CW-1:0]        cnt;

    logic signed [DW-1:0] ptch_rt_comp;
    logic signed [DW-1:0] az_comp;
    logic signed [PW-1:0] az_ext;
    logic signed [PW-1:0] acc_prod;
    logic signed [PW-1:0] acc_shift;
    logic signed [DW-1:0] ptch_acc;
    logic signed [DW-1:0] ptch_cur;
    logic signed [IW-1:0] gain;
    logic signed [IW-1:0] fus;
    logic signed [IW-1:0] rt_ext;
    logic signed [IW-1:0] ptch_nxt;

    // Offset correction and accel-derived pitch estimate
    always_comb begin
        ptch_rt_comp = $signed(ptch_rt) - $signed(PTCH_RT_OFFSET);
        az_comp      = $signed(AZ) - $signed(AZ_OFFSET);
        az_ext       = {{(PW-DW){az_comp[DW-1]}}, az_comp};
        acc_prod     = az_ext * SCALE;
        acc_shift    = acc_prod >>> 13;
        ptch_acc     = $signed(acc_shift[DW-1:0]);
        ptch_cur     = $signed(ptch_int[IW-1:IW-DW]);
        gain         = settled ? SLOW_G : FAST_G;
        fus          = (ptch_acc > ptch_cur) ? gain : -gain;
        rt_ext       = {{(IW-DW){ptch_rt_comp[DW-1]}}, ptch_rt_comp};
    end

`ifdef PTCH_SAT_EN
    logic signed [IW:0] sum_wide;

    // Wide sum then clamp to the 27b signed range
    always_comb begin
        sum_wide = {ptch_int[IW-1], ptch_int} - {rt_ext[IW-1], rt_ext} + {fus[IW-1], fus};
        if (sum_wide[IW] != sum_wide[IW-1]) begin
            ptch_nxt = sum_wide[IW] ? {1'b1, {(IW-1){1'b0}}} : {1'b0, {(IW-1){1'b1}}};
        end else begin
            ptch_nxt = sum_wide[IW-1:0];
        end
    end
`else
    always_comb begin
        ptch_nxt = ptch_int - rt_ext + fus;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptch_int <= '0;
            ptch_vld <= 1'b0;
            settled  <= 1'b0;
            cnt      <= '0;
        end else begin
            ptch_vld <= vld;
            if (vld) begin
                ptch_int <= ptch_nxt;
                // Count stops once settled; the last fast sample still used FAST_GAIN
                if (!settled) begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        settled <= 1'b1;
                    end
                end
            end
        end
    end

    assign ptch = ptch_int[IW-1:IW-DW];

endmodule
